tx_beamform: RTL

TX_BEAMFORM -- requirements
Module: tx_beamform

---
 rtl/tx_beamform_if.sv | 25 ++
 rtl/tx_beamform.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tx_beamform_if.sv
// Control and pulser-drive bundle between a line sequencer and the transmit beamformer.
// Signal names follow the pulser board's established naming.
interface tx_beamform_if;
  logic       Tx_Start;
  logic [1:0] Focus_Num;
  logic [7:0] Line_Num;
  logic [7:0] Ch_Mask;
  logic [7:0] Tx_P;
  logic [7:0] Tx_N;
  logic       Sample_Gate;
  logic       RX_Gate;
  logic [7:0] Tx_Line;
  logic       Tx_Busy;
  logic       Tx_Done;

  modport master (
    output Tx_Start, Focus_Num, Line_Num, Ch_Mask,
    input  Tx_P, Tx_N, Sample_Gate, RX_Gate, Tx_Line, Tx_Busy, Tx_Done
  );

  modport slave (
    input  Tx_Start, Focus_Num, Line_Num, Ch_Mask,
    output Tx_P, Tx_N, Sample_Gate, RX_Gate, Tx_Line, Tx_Busy, Tx_Done
  );
endinterface

// File: rtl/tx_beamform.sv
// Eight-channel transmit beamformer: fires one delayed bipolar burst per channel
// per line, with receive restart pulses aligned to the start of the fire window.
module tx_beamform #(
  parameter int unsigned HALF_PERIOD   = 4,
  parameter int unsigned N_CYCLES      = 2,
  parameter logic [63:0] DELAY_CENTER  = 64'h00020406080A0C0E,
  parameter logic [63:0] DELAY_OUTSIDE = 64'h1014181C20242830
) (
  input  logic        AD_CLK,
  input  logic        Rst,
  tx_beamform_if.slave bus
);
  localparam int unsigned BURST_LEN = 2 * HALF_PERIOD * N_CYCLES;
  localparam int unsigned FIRE_WIN  = 256 + BURST_LEN;
  localparam logic [9:0]  T_LAST    = 10'(FIRE_WIN - 1);
  localparam logic [9:0]  BURST_W   = 10'(BURST_LEN);
  localparam logic [9:0]  HALF_W    = 10'(HALF_PERIOD);

  typedef enum logic [1:0] {IDLE, LOAD, FIRE, DONE} state_e;

  state_e      state_q, state_d;
  logic [9:0]  t_q, t_d;
  logic [1:0]  focus_q, focus_d;
  logic [7:0]  line_q, line_d;
  logic [7:0]  mask_q, mask_d;
  logic [63:0] delay_q, delay_d;
  // Pipeline stage between the timer and the output registers.
  logic        act_q, act_d;
  logic [9:0]  tp_q, tp_d;
  logic [7:0]  tx_p_q, tx_p_d;
  logic [7:0]  tx_n_q, tx_n_d;
  logic        gate_q, gate_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    focus_d = focus_q;
    line_d  = line_q;
    mask_d  = mask_q;
    delay_d = delay_q;

    unique case (state_q)
      IDLE: if (bus.Tx_Start) begin
        state_d = LOAD;
        focus_d = bus.Focus_Num;
        line_d  = bus.Line_Num;
        mask_d  = bus.Ch_Mask;
      end
      LOAD: begin
        state_d = FIRE;
        t_d     = '0;
        delay_d = (focus_q == 2'b10) ? DELAY_OUTSIDE : DELAY_CENTER;
      end
      FIRE: begin
        if (t_q == T_LAST) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 10'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    act_d  = (state_q == FIRE);
    tp_d   = t_q;
    gate_d = act_q && (tp_q == '0);
    busy_d = (state_q != IDLE);
    done_d = (state_q == DONE);
  end

  // Per-channel burst shaping from the pipelined timer value.
  always_comb begin
    logic [9:0] d_w;
    logic [9:0] p_w;
    logic [9:0] q_w;
    tx_p_d = '0;
    tx_n_d = '0;
    d_w    = '0;
    p_w    = '0;
    q_w    = '0;
    for (int i = 0; i < 8; i++) begin
      d_w = {2'b00, delay_q[63-8*i -: 8]};
      p_w = tp_q - d_w;
      q_w = p_w / HALF_W;
      if (act_q && mask_q[7-i] && (tp_q >= d_w) && (p_w < BURST_W)) begin
        if (q_w[0]) tx_n_d[7-i] = 1'b1;
        else        tx_p_d[7-i] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge AD_CLK) begin
    if (Rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      focus_q <= '0;
      line_q  <= '0;
      mask_q  <= '0;
      act_q   <= 1'b0;
      tp_q    <= '0;
      tx_p_q  <= '0;
      tx_n_q  <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      focus_q <= focus_d;
      line_q  <= line_d;
      mask_q  <= mask_d;
      act_q   <= act_d;
      tp_q    <= tp_d;
      tx_p_q  <= tx_p_d;
      tx_n_q  <= tx_n_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: delay_q is always written in LOAD before FIRE reads it, so it carries no reset.
  always_ff @(posedge AD_CLK) begin
    delay_q <= delay_d;
  end

  assign bus.Tx_P        = tx_p_q;
  assign bus.Tx_N        = tx_n_q;
  assign bus.Sample_Gate = gate_q;
  assign bus.RX_Gate     = gate_q;
  assign bus.Tx_Line     = line_q;
  assign bus.Tx_Busy     = busy_q;
  assign bus.Tx_Done     = done_q;
endmodule
